// File: rtl/modular_exponentiator.sv
// ---------------------------------------------------------------------------
// modular_exponentiator
//
// Computes result = base^exponent mod p using left-to-right square-and-multiply.
// It does not multiply anything itself. Each multiplication is handed to an
// external modular_multiplier through the mul_* ports.
//
// Optional feature macro: SKIP_LEADING_ZEROS_EN
//   When this macro is defined, leading zero exponent bits are consumed without
//   issuing a squaring, because R is still 1 at that point. The result is the
//   same in both builds. Only the cycle count and the number of multiplier
//   transactions differ.
//
// Parameters
//   n      operand / modulus width (must match the attached multiplier)
//   EXP_W  exponent width in bits
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low; forces IDLE and reset outputs at once
//   start      one-cycle request, sampled only in IDLE
//   base       operand (< p)
//   exponent   exponent
//   p          odd modulus, p > 2
//   result     base^exponent mod p, held until the next completion
//   done       one-cycle pulse in the cycle result updates
//   busy       high from the cycle after start is accepted until done
//   mul_A      multiplier operand A
//   mul_B      multiplier operand B
//   mul_p      multiplier modulus (latched p)
//   mul_reset  active-high multiplier reset/start; low only while waiting
//   mul_M      multiplier product
//   mul_flag   multiplier done, only meaningful while mul_reset is low
// ---------------------------------------------------------------------------
module modular_exponentiator #(
    parameter int n     = 256,
    parameter int EXP_W = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [n-1:0]     base,
    input  logic [EXP_W-1:0] exponent,
    input  logic [n-1:0]     p,
    output logic [n-1:0]     result,
    output logic             done,
    output logic             busy,
    output logic [n-1:0]     mul_A,
    output logic [n-1:0]     mul_B,
    output logic [n-1:0]     mul_p,
    output logic             mul_reset,
    input  logic [n-1:0]     mul_M,
    input  logic             mul_flag
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [n-1:0]     ONE_N    = {{(n-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(EXP_W - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SQ_ISSUE  = 3'd1,
        SQ_WAIT   = 3'd2,
        MUL_ISSUE = 3'd3,
        MUL_WAIT  = 3'd4,
        NEXT      = 3'd5,
        FINISH    = 3'd6
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [n-1:0]      base_r;
    logic [EXP_W-1:0]  exp_r;
    logic [n-1:0]      r_r;
    logic [n-1:0]      r_next_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_next_s;
    logic [IDX_W-1:0]  idx_dec_s;
    logic              accept_s;
    logic              wait_next_s;

    logic [n-1:0]      result_r;
    logic              done_r;
    logic              busy_r;
    logic [n-1:0]      mul_a_r;
    logic [n-1:0]      mul_b_r;
    logic [n-1:0]      mul_p_r;
    logic              mul_reset_r;

`ifdef SKIP_LEADING_ZEROS_EN
    // Set once a one bit of the exponent has been consumed. After that point R
    // may differ from 1, so every remaining bit must be squared.
    logic              seen_r;
`endif

    assign accept_s    = (state_r == IDLE) && start;
    assign idx_dec_s   = idx_r - IDX_ONE;
    // The multiplier computes only while the sequencer sits in a WAIT state.
    assign wait_next_s = (next_state_s == SQ_WAIT) || (next_state_s == MUL_WAIT);

    // Next-state, next-R and next-index logic for the square-and-multiply walk
    always_comb begin
        next_state_s = state_r;
        r_next_s     = r_r;
        idx_next_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    r_next_s   = ONE_N;
                    idx_next_s = IDX_TOP;
`ifdef SKIP_LEADING_ZEROS_EN
                    if (exponent[EXP_W-1]) begin
                        next_state_s = SQ_ISSUE;
                    end else begin
                        next_state_s = NEXT;
                    end
`else
                    next_state_s = SQ_ISSUE;
`endif
                end else begin
                    next_state_s = IDLE;
                end
            end
            SQ_ISSUE: begin
                next_state_s = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (mul_flag) begin
                    r_next_s = mul_M;
                    if (exp_r[idx_r]) begin
                        next_state_s = MUL_ISSUE;
                    end else begin
                        next_state_s = NEXT;
                    end
                end else begin
                    next_state_s = SQ_WAIT;
                end
            end
            MUL_ISSUE: begin
                next_state_s = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mul_flag) begin
                    r_next_s     = mul_M;
                    next_state_s = NEXT;
                end else begin
                    next_state_s = MUL_WAIT;
                end
            end
            NEXT: begin
                if (idx_r == IDX_ZERO) begin
                    next_state_s = FINISH;
                end else begin
                    idx_next_s = idx_dec_s;
`ifdef SKIP_LEADING_ZEROS_EN
                    if (!seen_r && !exp_r[idx_dec_s]) begin
                        next_state_s = NEXT;
                    end else begin
                        next_state_s = SQ_ISSUE;
                    end
`else
                    next_state_s = SQ_ISSUE;
`endif
                end
            end
            FINISH: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Running value R and exponent bit index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_r   <= {n{1'b0}};
            idx_r <= IDX_ZERO;
        end else begin
            r_r   <= r_next_s;
            idx_r <= idx_next_s;
        end
    end

    // Operand capture on an accepted start; later input changes are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_r  <= {n{1'b0}};
            exp_r   <= {EXP_W{1'b0}};
            mul_p_r <= {n{1'b0}};
        end else if (accept_s) begin
            base_r  <= base;
            exp_r   <= exponent;
            mul_p_r <= p;
        end else begin
            base_r  <= base_r;
            exp_r   <= exp_r;
            mul_p_r <= mul_p_r;
        end
    end

`ifdef SKIP_LEADING_ZEROS_EN
    // Tracks whether the first one bit of the exponent has been reached
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seen_r <= 1'b0;
        end else if (accept_s) begin
            seen_r <= 1'b0;
        end else if ((state_r == SQ_WAIT) && mul_flag && exp_r[idx_r]) begin
            seen_r <= 1'b1;
        end else begin
            seen_r <= seen_r;
        end
    end
`endif

    // Multiplier interface. The outputs are registered from the next state so
    // that they line up exactly with the state that owns them. The operands are
    // loaded when an ISSUE state is entered and then held through the WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_a_r     <= {n{1'b0}};
            mul_b_r     <= {n{1'b0}};
            mul_reset_r <= 1'b1;
        end else begin
            mul_reset_r <= !wait_next_s;
            if (next_state_s == SQ_ISSUE) begin
                mul_a_r <= r_next_s;
                mul_b_r <= r_next_s;
            end else if (next_state_s == MUL_ISSUE) begin
                mul_a_r <= r_next_s;
                mul_b_r <= base_r;
            end else begin
                mul_a_r <= mul_a_r;
                mul_b_r <= mul_b_r;
            end
        end
    end

    // Completion outputs: result and done update together as FINISH is left
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_r <= {n{1'b0}};
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else if (state_r == FINISH) begin
            result_r <= r_r;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
        end else if (accept_s) begin
            result_r <= result_r;
            done_r   <= 1'b0;
            busy_r   <= 1'b1;
        end else begin
            result_r <= result_r;
            done_r   <= 1'b0;
            busy_r   <= busy_r;
        end
    end

    assign result    = result_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign mul_A     = mul_a_r;
    assign mul_B     = mul_b_r;
    assign mul_p     = mul_p_r;
    assign mul_reset = mul_reset_r;

endmodule

// File: tb/tb_modular_exponentiator.sv
// ---------------------------------------------------------------------------
// tb_modular_exponentiator
//
// Directed bench for modular_exponentiator. It uses two instances, each
// attached to a behavioural multiplier stub with a fixed latency:
//   sm_*  n=8,   EXP_W=8   : small vectors, pulse counts, start-while-busy,
//                            mid-run reset, protocol monitor, flag injection
//   bg_*  n=256, EXP_W=256 : Fermat inverse of 2 modulo the secp256k1 prime
// ---------------------------------------------------------------------------
module tb_modular_exponentiator;

`ifdef SKIP_LEADING_ZEROS_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    localparam logic [255:0] P256 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- small instance ----------------
    logic        sm_rst = 1'b0;
    logic        sm_start = 1'b0;
    logic [7:0]  sm_base = 8'd0;
    logic [7:0]  sm_exp = 8'd0;
    logic [7:0]  sm_p = 8'd0;
    logic [7:0]  sm_result, sm_a, sm_b, sm_mp;
    logic        sm_done, sm_busy, sm_mr;
    logic [7:0]  sm_m = 8'd0;
    logic        sm_flag;
    logic        sm_flag_r = 1'b0;
    logic        sm_inj = 1'b0;
    logic [2:0]  sm_cnt = 3'd0;
    logic        inj_en = 1'b0;
    logic        mon_en = 1'b0;

    modular_exponentiator #(.n(8), .EXP_W(8)) u_small (
        .clk(clk), .reset(sm_rst), .start(sm_start), .base(sm_base),
        .exponent(sm_exp), .p(sm_p), .result(sm_result), .done(sm_done),
        .busy(sm_busy), .mul_A(sm_a), .mul_B(sm_b), .mul_p(sm_mp),
        .mul_reset(sm_mr), .mul_M(sm_m), .mul_flag(sm_flag)
    );

    // Small multiplier stub: the product is ready after four cycles with mul_reset low
    always @(posedge clk) begin
        if (sm_mr) begin
            sm_cnt    <= 3'd0;
            sm_flag_r <= 1'b0;
        end else if (sm_cnt == 3'd3) begin
            sm_flag_r <= 1'b1;
            sm_m      <= 8'((16'(sm_a) * 16'(sm_b)) % 16'(sm_mp));
        end else begin
            sm_cnt <= sm_cnt + 3'd1;
        end
    end

    // Spurious flag pulses, driven only while mul_reset is high
    always @(negedge clk) begin
        sm_inj <= inj_en && sm_mr && ($urandom_range(0, 1) == 1);
    end
    assign sm_flag = sm_flag_r | sm_inj;

    // Protocol monitor: operand stability, low-run length, mul_reset pulses, done pulses
    logic        prev_mr = 1'b1;
    logic [7:0]  prev_a = 8'd0;
    logic [7:0]  prev_b = 8'd0;
    int          run_len = 0;
    int          stab_viol = 0;
    int          lowrun_viol = 0;
    int          pulses = 0;
    int          done_cnt = 0;
    always @(negedge clk) begin
        prev_mr <= sm_mr;
        prev_a  <= sm_a;
        prev_b  <= sm_b;
        if (sm_done) done_cnt <= done_cnt + 1;
        if (prev_mr && !sm_mr) pulses <= pulses + 1;
        if (!mon_en) begin
            run_len <= 0;
        end else if (!sm_mr) begin
            run_len <= run_len + 1;
            if (!prev_mr && ((sm_a != prev_a) || (sm_b != prev_b)))
                stab_viol <= stab_viol + 1;
        end else begin
            // WAIT lasts exactly 5 sampled cycles with this stub
            if (!prev_mr && (run_len != 5)) lowrun_viol <= lowrun_viol + 1;
            run_len <= 0;
        end
    end

    // ---------------- big instance ----------------
    logic          bg_rst = 1'b0;
    logic          bg_start = 1'b0;
    logic [255:0]  bg_base = 256'd0;
    logic [255:0]  bg_exp = 256'd0;
    logic [255:0]  bg_p = 256'd0;
    logic [255:0]  bg_result, bg_a, bg_b, bg_mp;
    logic          bg_done, bg_busy, bg_mr;
    logic [255:0]  bg_m = 256'd0;
    logic          bg_flag = 1'b0;
    logic [2:0]    bg_cnt = 3'd0;
    int            bg_pulses = 0;
    logic          bg_prev_mr = 1'b1;

    modular_exponentiator #(.n(256), .EXP_W(256)) u_big (
        .clk(clk), .reset(bg_rst), .start(bg_start), .base(bg_base),
        .exponent(bg_exp), .p(bg_p), .result(bg_result), .done(bg_done),
        .busy(bg_busy), .mul_A(bg_a), .mul_B(bg_b), .mul_p(bg_mp),
        .mul_reset(bg_mr), .mul_M(bg_m), .mul_flag(bg_flag)
    );

    // Wide multiplier stub with the same timing as the small one
    always @(posedge clk) begin
        if (bg_mr) begin
            bg_cnt  <= 3'd0;
            bg_flag <= 1'b0;
        end else if (bg_cnt == 3'd3) begin
            bg_flag <= 1'b1;
            bg_m    <= 256'(({256'd0, bg_a} * {256'd0, bg_b}) % {256'd0, bg_mp});
        end else begin
            bg_cnt <= bg_cnt + 3'd1;
        end
    end

    // Counts multiplier transactions on the wide instance
    always @(negedge clk) begin
        bg_prev_mr <= bg_mr;
        if (bg_prev_mr && !bg_mr) bg_pulses <= bg_pulses + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One small operation, optionally with a disturbing second start mid-run
    task automatic sm_run(input string tag, input logic [7:0] b, input logic [7:0] e,
                          input logic [7:0] pp, input logic [7:0] exp_res,
                          input int exp_pulses, input bit disturb);
        int p0;
        int d0;
        int cyc;
        int busy_drop;
        @(negedge clk);
        p0 = pulses;
        d0 = done_cnt;
        sm_base  = b;
        sm_exp   = e;
        sm_p     = pp;
        sm_start = 1'b1;
        @(negedge clk);
        sm_start = 1'b0;
        check({tag, "_busy_up"}, 256'(sm_busy), 256'd1);
        cyc = 0;
        busy_drop = 0;
        while (!sm_done && cyc < 1000) begin
            if (disturb && cyc == 10) begin
                sm_start = 1'b1;
                sm_base  = 8'd7;
                sm_exp   = 8'd5;
                sm_p     = 8'd11;
            end else if (disturb && cyc == 11) begin
                sm_start = 1'b0;
            end
            if (disturb && cyc == 13) check({tag, "_mul_p_held"}, 256'(sm_mp), 256'(pp));
            @(negedge clk);
            cyc++;
            if (!sm_done && !sm_busy) busy_drop++;
        end
        check({tag, "_timeout"}, 256'(cyc < 1000), 256'd1);
        check({tag, "_result"}, 256'(sm_result), 256'(exp_res));
        check({tag, "_busy_drop"}, 256'(busy_drop), 256'd0);
        check({tag, "_busy_at_done"}, 256'(sm_busy), 256'd0);
        @(negedge clk);
        check({tag, "_done_width"}, 256'(sm_done), 256'd0);
        check({tag, "_result_hold"}, 256'(sm_result), 256'(exp_res));
        check({tag, "_done_count"}, 256'(done_cnt - d0), 256'd1);
        check({tag, "_mul_pulses"}, 256'(pulses - p0), 256'(exp_pulses));
    endtask

    initial begin
        int cyc;
        int d0;
        logic [256:0] half;

        repeat (3) @(negedge clk);
        check("rst_result", 256'(sm_result), 256'd0);
        check("rst_done", 256'(sm_done), 256'd0);
        check("rst_busy", 256'(sm_busy), 256'd0);
        check("rst_mul_A", 256'(sm_a), 256'd0);
        check("rst_mul_B", 256'(sm_b), 256'd0);
        check("rst_mul_p", 256'(sm_mp), 256'd0);
        check("rst_mul_reset", 256'(sm_mr), 256'd1);
        sm_rst = 1'b1;
        bg_rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Small vectors; the pulse count is squarings plus popcount(exponent)
        sm_run("basic",    8'd5,  8'd3,   8'd23, 8'd10, SKIP ? 4 : 10, 1'b0);
        sm_run("exp0",     8'd5,  8'd0,   8'd23, 8'd1,  SKIP ? 0 : 8,  1'b0);
        sm_run("base0",    8'd0,  8'd7,   8'd23, 8'd0,  SKIP ? 6 : 11, 1'b0);
        inj_en = 1'b1;
        sm_run("allones",  8'd7,  8'd255, 8'd11, 8'd10, 16,            1'b0);
        sm_run("fermat",   8'd5,  8'd21,  8'd23, 8'd14, SKIP ? 8 : 11, 1'b0);
        sm_run("msbonly",  8'd2,  8'd128, 8'd23, 8'd13, 9,             1'b0);
        sm_run("pminus1",  8'd22, 8'd2,   8'd23, 8'd1,  SKIP ? 3 : 9,  1'b0);
        sm_run("busystart",8'd5,  8'd3,   8'd23, 8'd10, SKIP ? 4 : 10, 1'b1);

        // Mid-run reset while waiting on the base multiply (mul_A != mul_B)
        @(negedge clk);
        d0 = done_cnt;
        sm_base = 8'd5; sm_exp = 8'd3; sm_p = 8'd23;
        sm_start = 1'b1;
        @(negedge clk);
        sm_start = 1'b0;
        cyc = 0;
        while (!(!sm_mr && (sm_a != sm_b)) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst_reach_mulwait", 256'(cyc < 500), 256'd1);
        #2;
        mon_en = 1'b0;
        sm_rst = 1'b0;
        #1;
        check("midrst_result", 256'(sm_result), 256'd0);
        check("midrst_busy", 256'(sm_busy), 256'd0);
        check("midrst_mul_reset", 256'(sm_mr), 256'd1);
        check("midrst_done", 256'(sm_done), 256'd0);
        repeat (3) @(negedge clk);
        sm_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_done", 256'(done_cnt - d0), 256'd0);
        mon_en = 1'b1;
        sm_run("afterrst", 8'd5, 8'd3, 8'd23, 8'd10, SKIP ? 4 : 10, 1'b0);

        // Full-width Fermat inverse of 2 modulo the secp256k1 prime
        @(negedge clk);
        d0 = bg_pulses;
        bg_base = 256'd2;
        bg_exp  = P256 - 256'd2;
        bg_p    = P256;
        bg_start = 1'b1;
        @(negedge clk);
        bg_start = 1'b0;
        cyc = 0;
        while (!bg_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        half = ({1'b0, P256} + 257'd1) >> 1;
        check("big_timeout", 256'(cyc < 20000), 256'd1);
        check("big_result", bg_result, half[255:0]);
        check("big_inverse", 256'(({256'd0, bg_result} * 512'd2) % {256'd0, P256}), 256'd1);
        // The top bit of p-2 is set, so both builds square all 256 bits
        check("big_mul_pulses", 256'(bg_pulses - d0), 256'(256 + $countones(P256 - 256'd2)));

        check("proto_operand_stable", 256'(stab_viol), 256'd0);
        check("proto_wait_length", 256'(lowrun_viol), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
